alu_tmr_scheduler: RTL and testbench

Shares one triple-redundant ALU datapath among NUM_REQ requesters. It arbitrates round-robin, executes each granted operation on three `alu` replicas, and votes the results 2-of-3. When no majority exists it retries up to MAX_RETRY times, then returns a tagged result or fault status on a single valid/ready response port. It sits between the execute-stage issue logic and the writeback mux, and also serves non-pipelined units that need ALU time.

---
 rtl/alu_tmr_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_tmr_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_tmr_scheduler.sv
// Round-robin shared ALU with three voted replicas and bounded retry.
// One request in flight; response held on a valid/ready port.
module alu_tmr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MAX_RETRY = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_operand_a,
    input  logic [NUM_REQ*32-1:0] req_operand_b,
    input  logic [NUM_REQ*4-1:0] req_alu_control,
    input  logic [2:0]           inj_mask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_fault,
    output logic                 rsp_corrected,
    output logic [1:0]           rsp_retries,
    output logic [15:0]          fault_count,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [1:0]    retry_q, retry_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]   rsp_result_q, rsp_result_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_fault_q, rsp_fault_d;
    logic          rsp_corr_q, rsp_corr_d;
    logic [1:0]    rsp_retries_q, rsp_retries_d;
    logic [15:0]   fault_count_q, fault_count_d;

    logic [IW-1:0] grant_idx;
    logic          grant_found;
    logic [31:0]   alu_res [3];
    logic [31:0]   rep [3];
    logic [31:0]   voted;
    logic          vote_err;
    logic          corrected;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_inc(rr_ptr_q, k)]) begin
                grant_idx   = wrap_inc(rr_ptr_q, k);
                grant_found = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_rep
        alu u_alu (
            .a           (op_a_q),
            .b           (op_b_q),
            .alu_control (ctrl_q),
            .result      (alu_res[k])
        );
        assign rep[k] = alu_res[k] ^ (inj_mask[k] ? (32'h1 << k) : 32'h0);
    end

    // 2-of-3 vote over the (possibly injected) replica results
    always_comb begin
        voted     = '0;
        vote_err  = 1'b0;
        corrected = 1'b0;
        if (rep[0] == rep[1] || rep[0] == rep[2]) begin
            voted     = rep[0];
            corrected = !(rep[0] == rep[1] && rep[0] == rep[2]);
        end else if (rep[1] == rep[2]) begin
            voted     = rep[1];
            corrected = 1'b1;
        end else begin
            vote_err  = 1'b1;
        end
    end

    // Next-state, grant and response capture
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        ctrl_d        = ctrl_q;
        retry_d       = retry_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_corr_d    = rsp_corr_q;
        rsp_retries_d = rsp_retries_q;
        fault_count_d = fault_count_q;
        req_ready     = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    op_a_d   = req_operand_a[int'(grant_idx)*32 +: 32];
                    op_b_d   = req_operand_b[int'(grant_idx)*32 +: 32];
                    ctrl_d   = req_alu_control[int'(grant_idx)*4 +: 4];
                    id_d     = grant_idx;
                    rr_ptr_d = wrap_inc(grant_idx, 1);
                    retry_d  = 2'd0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (!vote_err) begin
                    rsp_id_d      = id_q;
                    rsp_result_d  = voted;
                    rsp_zero_d    = (voted == 32'h0);
                    rsp_fault_d   = 1'b0;
                    rsp_corr_d    = corrected;
                    rsp_retries_d = retry_q;
                    state_d       = RESP;
                end else if (retry_q != 2'(MAX_RETRY)) begin
                    retry_d = retry_q + 2'd1;
                end else begin
                    rsp_id_d      = id_q;
                    rsp_result_d  = '0;
                    rsp_zero_d    = 1'b0;
                    rsp_fault_d   = 1'b1;
                    rsp_corr_d    = 1'b0;
                    rsp_retries_d = retry_q;
                    if (fault_count_q != 16'hFFFF) begin
                        fault_count_d = fault_count_q + 16'd1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            ctrl_q        <= '0;
            retry_q       <= '0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_corr_q    <= 1'b0;
            rsp_retries_q <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            ctrl_q        <= ctrl_d;
            retry_q       <= retry_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_corr_q    <= rsp_corr_d;
            rsp_retries_q <= rsp_retries_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign rsp_valid     = (state_q == RESP);
    assign busy          = (state_q != IDLE);
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_fault     = rsp_fault_q;
    assign rsp_corrected = rsp_corr_q;
    assign rsp_retries   = rsp_retries_q;
    assign fault_count   = fault_count_q;

endmodule

// Single-cycle ALU replica: ADD SUB AND OR XOR SLL SRL, others give 0.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result
);

    // Operation select
    always_comb begin
        result = '0;
        case (alu_control)
            4'b0000: result = a + b;
            4'b0001: result = a - b;
            4'b0010: result = a & b;
            4'b0011: result = a | b;
            4'b0100: result = a ^ b;
            4'b0101: result = a << b[4:0];
            4'b0110: result = a >> b[4:0];
            default: result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_tmr_scheduler.sv
// Directed and randomized checks of alu_tmr_scheduler against a
// behavioural model of arbitration, voting and retry.
module tb_alu_tmr_scheduler;

    localparam int N  = 4;
    localparam int MR = 2;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_operand_a;
    logic [N*32-1:0] req_operand_b;
    logic [N*4-1:0]  req_alu_control;
    logic [2:0]      inj_mask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_zero;
    logic            rsp_fault;
    logic            rsp_corrected;
    logic [1:0]      rsp_retries;
    logic [15:0]     fault_count;
    logic            busy;

    alu_tmr_scheduler #(.NUM_REQ(N), .MAX_RETRY(MR)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_operand_a   (req_operand_a),
        .req_operand_b   (req_operand_b),
        .req_alu_control (req_alu_control),
        .inj_mask        (inj_mask),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_result      (rsp_result),
        .rsp_zero        (rsp_zero),
        .rsp_fault       (rsp_fault),
        .rsp_corrected   (rsp_corrected),
        .rsp_retries     (rsp_retries),
        .fault_count     (fault_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int ptr = 0;
    int fcnt = 0;
    int last_g = 0;
    int last_gcyc = 0;

    logic [31:0] qa [N];
    logic [31:0] qb [N];
    logic [3:0]  qc [N];
    logic [N-1:0] vreq;
    logic [2:0]  inj_plan [4];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always_comb begin
        req_operand_a   = '0;
        req_operand_b   = '0;
        req_alu_control = '0;
        for (int i = 0; i < N; i++) begin
            req_operand_a[32*i +: 32]  = qa[i];
            req_operand_b[32*i +: 32]  = qb[i];
            req_alu_control[4*i +: 4]  = qc[i];
        end
    end
    assign req_valid = vreq;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        int sh;
        sh = int'(b % 32);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inj_mask = 3'b000;
        cyc();
        cyc();
        rst = 1'b0;
        ptr = 0;
        fcnt = 0;
    endtask

    task automatic new_op(input int i);
        qa[i] = $urandom;
        qb[i] = ($urandom_range(0, 3) == 0) ? qa[i] : $urandom;
        qc[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({pfx, "_rsp_id"}, 32'(rsp_id), 32'h0);
        chk({pfx, "_rsp_result"}, rsp_result, 32'h0);
        chk({pfx, "_rsp_zero"}, 32'(rsp_zero), 32'h0);
        chk({pfx, "_rsp_fault"}, 32'(rsp_fault), 32'h0);
        chk({pfx, "_rsp_corr"}, 32'(rsp_corrected), 32'h0);
        chk({pfx, "_rsp_retries"}, 32'(rsp_retries), 32'h0);
        chk({pfx, "_fault_count"}, 32'(fault_count), 32'h0);
        chk({pfx, "_busy"}, 32'(busy), 32'h0);
    endtask

    // One full transaction from IDLE back to IDLE, or aborted by reset in EXEC.
    task automatic serve(input int hold, input bit keep, input bit abort);
        int g, att, cnt;
        bit done, corr;
        logic [31:0] tru, maj, exp_res;
        logic [31:0] r [3];
        #1;
        g = pick(ptr, vreq);
        chk("grant_onehot", 32'(req_ready), 32'(1 << g));
        chk("idle_busy", 32'(busy), 32'h0);
        tru = ref_alu(qa[g], qb[g], qc[g]);
        done = 1'b0;
        corr = 1'b0;
        exp_res = 32'h0;
        maj = 32'h0;
        att = 0;
        for (int a = 0; a <= MR; a++) begin
            if (!done) begin
                for (int k = 0; k < 3; k++)
                    r[k] = tru ^ (inj_plan[a][k] ? (32'h1 << k) : 32'h0);
                att = a + 1;
                for (int i = 0; i < 3; i++) begin
                    cnt = 0;
                    for (int j = 0; j < 3; j++) if (r[j] == r[i]) cnt++;
                    if (cnt >= 2) begin
                        done = 1'b1;
                        maj = r[i];
                    end
                end
                if (done) begin
                    exp_res = maj;
                    corr = (r[0] != maj) || (r[1] != maj) || (r[2] != maj);
                end
            end
        end
        last_g = g;
        last_gcyc = cyc_n;
        ptr = (g + 1) % N;
        cyc();
        if (!keep) vreq[g] = 1'b0;
        if (abort) begin
            rst = 1'b1;
            cyc();
            chk_reset_outputs("abort");
            chk("abort_ready", 32'(req_ready), 32'h0);
            rst = 1'b0;
            ptr = 0;
            fcnt = 0;
            return;
        end
        if (!done && fcnt < 65535) fcnt++;
        for (int a = 0; a < att; a++) begin
            chk("exec_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("exec_ready", 32'(req_ready), 32'h0);
            inj_mask = inj_plan[a];
            cyc();
        end
        inj_mask = 3'b000;
        chk("rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_zero", 32'(rsp_zero), 32'(done && exp_res == 32'h0));
        chk("rsp_fault", 32'(rsp_fault), 32'(!done));
        chk("rsp_corr", 32'(rsp_corrected), 32'(corr));
        chk("rsp_retries", 32'(rsp_retries), 32'(att - 1));
        chk("fault_count", 32'(fault_count), 32'(fcnt));
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            cyc();
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_result", rsp_result, exp_res);
            chk("hold_id", 32'(rsp_id), 32'(g));
            chk("hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        cyc();
        chk("back_idle_valid", 32'(rsp_valid), 32'h0);
    endtask

    task automatic clear_plan();
        for (int a = 0; a < 4; a++) inj_plan[a] = 3'b000;
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        vreq = '0;
        rsp_ready = 1'b1;
        inj_mask = 3'b000;
        for (int i = 0; i < N; i++) begin
            qa[i] = '0;
            qb[i] = '0;
            qc[i] = '0;
        end
        clear_plan();
        @(negedge clk);
        do_reset();
        chk_reset_outputs("reset");
        chk("reset_ready", 32'(req_ready), 32'h0);

        // ADD 5+7 from requester 2
        qa[2] = 32'd5;
        qb[2] = 32'd7;
        qc[2] = 4'd0;
        vreq = 4'b0100;
        serve(0, 1'b0, 1'b0);
        chk("t1_grant", 32'(last_g), 32'd2);

        // All four held from reset: order 0,1,2,3,0 every 3 cycles
        for (int i = 0; i < N; i++) new_op(i);
        vreq = 4'hF;
        rst = 1'b1;
        #1;
        chk("ready_in_rst", 32'(req_ready), 32'h0);
        do_reset();
        serve(0, 1'b1, 1'b0);
        chk("rr_first", 32'(last_g), 32'd0);
        for (int n = 1; n < 5; n++) begin
            t0 = last_gcyc;
            serve(0, 1'b1, 1'b0);
            chk("rr_order", 32'(last_g), 32'(n % N));
            chk("rr_gap", 32'(last_gcyc - t0), 32'd3);
        end
        vreq = '0;

        // SUB 9-9 with one replica corrupted
        qa[1] = 32'd9;
        qb[1] = 32'd9;
        qc[1] = 4'd1;
        vreq = 4'b0010;
        inj_plan[0] = 3'b010;
        serve(0, 1'b0, 1'b0);
        clear_plan();

        // XOR with no majority on the first attempt only
        qa[3] = 32'hF0;
        qb[3] = 32'h0F;
        qc[3] = 4'd4;
        vreq = 4'b1000;
        inj_plan[0] = 3'b011;
        serve(0, 1'b0, 1'b0);
        clear_plan();

        // AND with every attempt corrupted -> fault
        qa[0] = 32'hFFFF_0000;
        qb[0] = 32'h0F0F_0F0F;
        qc[0] = 4'd2;
        vreq = 4'b0001;
        for (int a = 0; a < 4; a++) inj_plan[a] = 3'b111;
        serve(0, 1'b0, 1'b0);
        chk("t5_fault_count", 32'(fault_count), 32'd1);
        clear_plan();

        // Back-pressure, then reset during EXEC
        new_op(2);
        vreq = 4'b0100;
        serve(5, 1'b0, 1'b0);
        new_op(1);
        vreq = 4'b0010;
        serve(0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) new_op(i);
        vreq = 4'hF;
        serve(0, 1'b0, 1'b0);
        chk("post_rst_ptr", 32'(last_g), 32'd0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!vreq[i] && $urandom_range(0, 1) == 1) begin
                    new_op(i);
                    vreq[i] = 1'b1;
                end
            end
            if (vreq == '0) begin
                new_op(it % N);
                vreq[it % N] = 1'b1;
            end
            for (int a = 0; a < 4; a++)
                inj_plan[a] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            serve($urandom_range(0, 2), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
